// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file
//  Purpose  : Integer register file with a valid/ready read-request port,
//             a one-deep registered response stage and an independent
//             writeback port. x0 reads as zero and ignores writes.
//  Option   : REG_FILE_BYPASS_EN - a read accepted on the same edge as a
//             matching writeback captures the incoming wr_data.
//  Revision : 1.0 - initial release
// ============================================================================
module reg_file #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    localparam int ADDR_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_rs1,
    input  logic [ADDR_W-1:0] req_rs2,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rs1_data,
    output logic [DATA_W-1:0] rsp_rs2_data,

    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_rd,
    input  logic [DATA_W-1:0] wr_data
);

    // Storage starts at index 1: x0 has no flops and is never selected.
    logic [DATA_W-1:0] r_regs [1:NUM_REGS-1];

    logic              w_accept;
    logic [DATA_W-1:0] w_rs1_arr;
    logic [DATA_W-1:0] w_rs2_arr;
    logic [DATA_W-1:0] w_rs1_next;
    logic [DATA_W-1:0] w_rs2_next;

    // ------------------------------------------------------------------
    // Writeback: address 0 and addresses beyond the file match no entry.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wr_en) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (wr_rd == ADDR_W'(i)) begin
                    r_regs[i] <= wr_data;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Array read: unmatched addresses (x0, out of range) fall to zero.
    // ------------------------------------------------------------------
    always_comb begin
        w_rs1_arr = '0;
        w_rs2_arr = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (req_rs1 == ADDR_W'(i)) begin
                w_rs1_arr = r_regs[i];
            end
            if (req_rs2 == ADDR_W'(i)) begin
                w_rs2_arr = r_regs[i];
            end
        end
    end

`ifdef REG_FILE_BYPASS_EN
    localparam logic [ADDR_W:0] c_num_regs = (ADDR_W + 1)'(NUM_REGS);

    logic w_wr_live;

    // A writeback only forwards when it would really land in the array.
    assign w_wr_live = wr_en && (wr_rd != '0) && ({1'b0, wr_rd} < c_num_regs);

    always_comb begin
        w_rs1_next = w_rs1_arr;
        w_rs2_next = w_rs2_arr;
        if (w_wr_live && (wr_rd == req_rs1)) begin
            w_rs1_next = wr_data;
        end
        if (w_wr_live && (wr_rd == req_rs2)) begin
            w_rs2_next = wr_data;
        end
    end
`else
    assign w_rs1_next = w_rs1_arr;
    assign w_rs2_next = w_rs2_arr;
`endif

    // ------------------------------------------------------------------
    // One-deep response stage. Operands are captured only on acceptance,
    // so a stalled response never picks up later writebacks.
    // ------------------------------------------------------------------
    assign req_ready = !rsp_valid || rsp_ready;
    assign w_accept  = req_valid && req_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid    <= 1'b0;
            rsp_rs1_data <= '0;
            rsp_rs2_data <= '0;
        end else if (w_accept) begin
            rsp_valid    <= 1'b1;
            rsp_rs1_data <= w_rs1_next;
            rsp_rs2_data <= w_rs2_next;
        end else if (rsp_ready) begin
            rsp_valid    <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_file
//  Purpose  : Scoreboard bench for reg_file: an array model predicts each
//             accepted read, a negedge monitor compares the response stage.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;

    typedef struct {
        logic [DATA_W-1:0] d1;
        logic [DATA_W-1:0] d2;
    } rsp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [ADDR_W-1:0] req_rs1 = '0;
    logic [ADDR_W-1:0] req_rs2 = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [DATA_W-1:0] rsp_rs1_data;
    logic [DATA_W-1:0] rsp_rs2_data;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_rd = '0;
    logic [DATA_W-1:0] wr_data = '0;

    reg_file #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_rs1      (req_rs1),
        .req_rs2      (req_rs2),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rs1_data (rsp_rs1_data),
        .rsp_rs2_data (rsp_rs2_data),
        .wr_en        (wr_en),
        .wr_rd        (wr_rd),
        .wr_data      (wr_data)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    bit   started  = 1'b0;

    logic [DATA_W-1:0] m_regs [NUM_REGS];
    bit                m_valid;
    rsp_t              q [$];
    rsp_t              last_rsp;

    task automatic chk(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural read of one operand as seen on the accepting edge.
    function automatic logic [DATA_W-1:0] model_read(input logic [ADDR_W-1:0] a);
        if (a == 0 || int'(a) >= NUM_REGS) return '0;
`ifdef REG_FILE_BYPASS_EN
        if (wr_en && wr_rd == a) return wr_data;
`endif
        return m_regs[a];
    endfunction

    // Reference model: advances at each rising edge outside reset.
    always @(posedge clk) begin
        if (!rst && started) begin
            bit   acc;
            rsp_t e;
            acc = req_valid && (!m_valid || rsp_ready);
            if (acc) begin
                e.d1 = model_read(req_rs1);
                e.d2 = model_read(req_rs2);
                q.push_back(e);
            end
            m_valid = acc || (m_valid && !rsp_ready);
            if (wr_en && wr_rd != 0 && int'(wr_rd) < NUM_REGS) m_regs[wr_rd] = wr_data;
        end
    end

    // Monitor: compares the response stage away from the active edge.
    always @(negedge clk) begin
        if (!rst && started) begin
            chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_valid});
            chk("req_ready", {31'd0, req_ready}, {31'd0, (!m_valid || rsp_ready)});
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: got rsp_valid=1 required no response");
                end else begin
                    chk("rs1_data", rsp_rs1_data, q[0].d1);
                    chk("rs2_data", rsp_rs2_data, q[0].d2);
                    if (rsp_ready) last_rsp = q.pop_front();
                end
            end else begin
                chk("idle_rs1_hold", rsp_rs1_data, last_rsp.d1);
                chk("idle_rs2_hold", rsp_rs2_data, last_rsp.d2);
            end
        end
    end

    task automatic step(input logic rv, input int a1, input int a2, input logic rr,
                        input logic we, input int wd_rd, input logic [DATA_W-1:0] wd);
        req_valid = rv;
        req_rs1   = ADDR_W'(a1);
        req_rs2   = ADDR_W'(a2);
        rsp_ready = rr;
        wr_en     = we;
        wr_rd     = ADDR_W'(wd_rd);
        wr_data   = wd;
        @(posedge clk);
        #1;
    endtask

    // Asserts reset off-edge, checks the asynchronous clear, then releases.
    task automatic do_reset();
        rst = 1'b1;
        q.delete();
        m_valid = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
        last_rsp.d1 = '0;
        last_rsp.d2 = '0;
        #1;
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_rs1_data", rsp_rs1_data, '0);
        chk("reset_rs2_data", rsp_rs2_data, '0);
        req_valid = 1'b0;
        wr_en     = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        started = 1'b1;
        chk("post_reset_ready", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        do_reset();

        // Write then read back, x0 reads zero.
        step(0, 0, 0, 1, 1, 5, 32'hDEADBEEF);
        step(1, 5, 0, 1, 0, 0, '0);
        step(0, 0, 0, 1, 1, 0, 32'h12345678);
        step(1, 0, 0, 1, 0, 0, '0);

        // Same-edge write and read of x3, then plain re-read.
        step(0, 0, 0, 1, 1, 3, 32'h11);
        step(1, 3, 3, 1, 1, 3, 32'h22);
        step(1, 3, 0, 1, 0, 0, '0);
        step(0, 0, 0, 1, 0, 0, '0);

        // Stall with a held response while x7 is rewritten.
        step(0, 0, 0, 1, 1, 7, 32'hA);
        step(1, 7, 7, 0, 0, 0, '0);
        repeat (3) step(1, 7, 1, 0, 1, 7, 32'hB);
        step(1, 7, 0, 1, 0, 0, '0);
        step(0, 0, 0, 1, 0, 0, '0);

        // Full-throughput stream over x1..x31.
        for (int i = 1; i < NUM_REGS; i++) step(0, 0, 0, 1, 1, i, DATA_W'($urandom));
        for (int i = 1; i < NUM_REGS; i++) step(1, i, NUM_REGS - i, 1, 0, 0, '0);
        step(0, 0, 0, 1, 0, 0, '0);

        // Randomized traffic with frequent read/write address collisions.
        for (int n = 0; n < 400; n++) begin
            int a1, a2, wrd;
            a1  = ($urandom % 2) ? int'($urandom % 8) : int'($urandom % NUM_REGS);
            a2  = ($urandom % 2) ? int'($urandom % 8) : int'($urandom % NUM_REGS);
            wrd = int'($urandom % 8);
            step(($urandom % 4) != 0, a1, a2, ($urandom % 4) != 0,
                 ($urandom % 2) != 0, wrd, DATA_W'($urandom));
        end

        // Reset in the middle of a stall with a response held.
        step(1, 1, 2, 0, 0, 0, '0);
        step(1, 3, 4, 0, 0, 0, '0);
        #3;
        do_reset();
        for (int i = 0; i < NUM_REGS; i++) step(1, i, NUM_REGS - 1 - i, 1, 0, 0, '0);

        repeat (3) step(0, 0, 0, 1, 0, 0, '0);
        chk("queue_drained", q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
